// File: rtl/gray2rgb565_pkg.sv
// Shared definitions for the gray-to-RGB565 colour mapper: mode encodings,
// RGB565 field layout and the default binary threshold.
package gray2rgb_pkg;

  typedef enum logic [1:0] {
    MODE_GRAY = 2'd0,
    MODE_HEAT = 2'd1,
    MODE_BIN  = 2'd2,
    MODE_INV  = 2'd3
  } mode_e;

  localparam int R_LSB   = 11;
  localparam int R_W     = 5;
  localparam int G_LSB   = 5;
  localparam int G_W     = 6;
  localparam int B_LSB   = 0;
  localparam int B_W     = 5;
  localparam int PIX_W   = 16;
  localparam int ENTRY_W = PIX_W + 2;

  localparam logic [7:0] THRESH_DEFAULT = 8'd128;

  function automatic logic [PIX_W-1:0] pack565(input logic [R_W-1:0] r,
                                               input logic [G_W-1:0] g,
                                               input logic [B_W-1:0] b);
    logic [PIX_W-1:0] px;
    px = '0;
    px[R_LSB +: R_W] = r;
    px[G_LSB +: G_W] = g;
    px[B_LSB +: B_W] = b;
    return px;
  endfunction

endpackage

// File: rtl/gray2rgb565_if.sv
// Pixel stream bundle: gray input handshake and RGB565 output handshake.
interface gray2rgb565_if;
  import gray2rgb_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_gray;
  logic             in_sof;
  logic             in_eol;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_rgb;
  logic             out_sof;
  logic             out_eol;

  modport slave (
    input  in_valid, in_gray, in_sof, in_eol, out_ready,
    output in_ready, out_valid, out_rgb, out_sof, out_eol
  );

  modport master (
    output in_valid, in_gray, in_sof, in_eol, out_ready,
    input  in_ready, out_valid, out_rgb, out_sof, out_eol
  );
endinterface

// File: rtl/gray2rgb565_px_fifo.sv
// Synchronous output buffer; storage array plus a registered head entry so the
// consumer sees flopped data and flags.
module px_fifo
  import gray2rgb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic         head_vld_o,
  output logic [W-1:0] head_data_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             head_vld_q;
  logic [W-1:0]     head_q;
  logic             push, load;

  // The head refills whenever it is empty or being consumed this cycle.
  always_comb begin
    push  = wr_en_i && (cnt_q != CNT_W'(DEPTH));
    load  = (cnt_q != '0) && (!head_vld_q || rd_en_i);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(load);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        head_q     <= mem_q[rd_ptr_q];
        head_vld_q <= 1'b1;
      end else if (rd_en_i && head_vld_q) begin
        head_vld_q <= 1'b0;
      end
    end
  end

  assign head_vld_o  = head_vld_q;
  assign head_data_o = head_q;

endmodule

// File: rtl/gray2rgb565.sv
// Gray-to-RGB565 colour mapper with per-frame mode latch, line-length
// measurement and an occupancy-tracked output buffer.
module gray2rgb565
  import gray2rgb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [7:0]       thresh,
  gray2rgb565_if.slave     pix,
  output logic [LEN_W-1:0] line_len,
  output logic             line_len_vld
);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic             in_fire, out_fire;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             in_ready_q;
  mode_e            mode_act_q, mode_use;
  logic [7:0]       thresh_act_q, thresh_use;
  logic [LEN_W-1:0] pix_cnt_q, pix_cnt_d, cur_len;
  logic [LEN_W-1:0] line_len_q;
  logic             line_len_vld_q;

  logic             vld_p1;
  logic [7:0]       gray_p1;
  logic             sof_p1, eol_p1;
  mode_e            mode_p1;
  logic [7:0]       thresh_p1;
  logic [PIX_W-1:0] rgb_p2;

  logic               head_vld;
  logic [ENTRY_W-1:0] head_data;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
    return (&c) ? c : c + LEN_W'(1);
  endfunction

  function automatic logic [PIX_W-1:0] map_rgb(input mode_e m, input logic [7:0] g,
                                               input logic [7:0] th);
    logic [5:0]       k;
    logic [PIX_W-1:0] px;
    k  = g[5:0];
    px = '0;
    case (m)
      MODE_GRAY: px = pack565(g[7:3], g[7:2], g[7:3]);
      MODE_INV:  px = pack565(~g[7:3], ~g[7:2], ~g[7:3]);
      MODE_BIN:  px = (g >= th) ? 16'hFFFF : 16'h0000;
      MODE_HEAT: begin
        case (g[7:6])
          2'd0:    px = pack565(5'd0, k, 5'd31);
          2'd1:    px = pack565(5'd0, 6'd63, 5'd31 - k[5:1]);
          2'd2:    px = pack565(k[5:1], 6'd63, 5'd0);
          default: px = pack565(5'd31, 6'd63 - k, 5'd0);
        endcase
      end
      default:   px = '0;
    endcase
    return px;
  endfunction

  assign in_fire      = pix.in_valid && in_ready_q;
  assign out_fire     = head_vld && pix.out_ready;
  assign pix.in_ready = in_ready_q;

  // Occupancy spans pipeline and buffer, so the buffer can never overflow.
  always_comb begin
    occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
  end

  // A start-of-frame pixel already uses the mode/threshold presented with it.
  always_comb begin
    mode_use   = mode_act_q;
    thresh_use = thresh_act_q;
    if (pix.in_sof) begin
      mode_use   = mode_e'(mode);
      thresh_use = thresh;
    end
  end

  always_comb begin
    cur_len   = pix.in_sof ? LEN_W'(1) : sat_inc(pix_cnt_q);
    pix_cnt_d = pix_cnt_q;
    if (in_fire) pix_cnt_d = pix.in_eol ? '0 : cur_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q          <= '0;
      in_ready_q     <= 1'b0;
      mode_act_q     <= MODE_GRAY;
      thresh_act_q   <= THRESH_DEFAULT;
      pix_cnt_q      <= '0;
      line_len_q     <= '0;
      line_len_vld_q <= 1'b0;
      vld_p1         <= 1'b0;
    end else begin
      occ_q          <= occ_d;
      in_ready_q     <= (occ_d < OCC_W'(FIFO_DEPTH));
      pix_cnt_q      <= pix_cnt_d;
      line_len_vld_q <= in_fire && pix.in_eol;
      vld_p1         <= in_fire;
      if (in_fire && pix.in_sof) begin
        mode_act_q   <= mode_use;
        thresh_act_q <= thresh_use;
      end
      if (in_fire && pix.in_eol) line_len_q <= cur_len;
    end
  end

  // Stage 1: capture pixel, flags and the mode it is to be converted with.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      gray_p1   <= pix.in_gray;
      sof_p1    <= pix.in_sof;
      eol_p1    <= pix.in_eol;
      mode_p1   <= mode_use;
      thresh_p1 <= thresh_use;
    end
  end

  // Stage 2: colour conversion, written straight into the output buffer.
  assign rgb_p2 = map_rgb(mode_p1, gray_p1, thresh_p1);

  px_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (vld_p1),
    .wr_data_i   ({sof_p1, eol_p1, rgb_p2}),
    .rd_en_i     (pix.out_ready),
    .head_vld_o  (head_vld),
    .head_data_o (head_data)
  );

  assign pix.out_valid = head_vld;
  assign pix.out_sof   = head_data[ENTRY_W-1];
  assign pix.out_eol   = head_data[ENTRY_W-2];
  assign pix.out_rgb   = head_data[PIX_W-1:0];
  assign line_len      = line_len_q;
  assign line_len_vld  = line_len_vld_q;

endmodule

// File: doc/gray2rgb565.md
GRAY2RGB565 -- requirements
Module: gray2rgb565

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, output buffer depth in pixels (power of two, >= 4).
REQ-002 Parameter: LEN_W, default 12, width of the line-length counter.
REQ-003 Port: clk  input  1  system clock, all logic rising-edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: mode  input  2  color mode: 0 gray, 1 heatmap, 2 binary, 3 inverted gray.
REQ-006 Port: thresh  input  8  binary-mode threshold.
REQ-007 Port: in_valid  input  1  input pixel valid.
REQ-008 Port: in_ready  output  1  block can accept a pixel.
REQ-009 Port: in_gray  input  8  8-bit gray pixel.
REQ-010 Port: in_sof  input  1  pixel is first of frame.
REQ-011 Port: in_eol  input  1  pixel is last of line.
REQ-012 Port: out_valid  output  1  output pixel valid.
REQ-013 Port: out_ready  input  1  sink accepts output pixel.
REQ-014 Port: out_rgb  output  16  RGB565 pixel, R[15:11] G[10:5] B[4:0].
REQ-015 Port: out_sof / out_eol  output  1 each  flags travelling with the pixel.
REQ-016 Port: line_len  output  LEN_W  pixel count of the last completed line.
REQ-017 Port: line_len_vld  output  1  one-cycle pulse when line_len updates.

Function
REQ-018 Input transfer SHALL occur on in_valid && in_ready; output transfer SHALL occur on out_valid && out_ready.
REQ-019 occupancy SHALL count pixels accepted but not yet delivered; in_ready SHALL be (occupancy < FIFO_DEPTH), derived from registered state only.
REQ-020 Simultaneous input and output transfer SHALL leave occupancy unchanged.
REQ-021 Pipeline: stage 1 registers gray/flags/active mode; stage 2 computes RGB and writes the FIFO; a pixel accepted at edge N SHALL be visible on out_rgb with out_valid at the cycle after edge N+2 when the FIFO is empty.
REQ-022 With out_ready held high, throughput SHALL be one pixel per cycle, no bubbles.
REQ-023 mode and thresh SHALL be latched into active registers only on an accepted in_sof pixel, and that pixel SHALL already use the new values.
REQ-024 Mode 0: R=g[7:3], G=g[7:2], B=g[7:3].
REQ-025 Mode 3: same as mode 0 using ~g.
REQ-026 Mode 2: out_rgb = 16'hFFFF if g >= thresh, else 16'h0000.
REQ-027 Mode 1, k=g[5:0]: g[7:6]=0 -> R=0,G=k,B=31; 1 -> R=0,G=63,B=31-k[5:1]; 2 -> R=k[5:1],G=63,B=0; 3 -> R=31,G=63-k,B=0.
REQ-028 out_rgb/out_sof/out_eol SHALL remain stable while out_valid && !out_ready.
REQ-029 pix_cnt SHALL increment per accepted pixel and saturate at 2^LEN_W-1; an accepted in_sof pixel SHALL restart the count at 1.
REQ-030 On an accepted in_eol pixel, line_len SHALL load the count including that pixel, line_len_vld SHALL pulse the next cycle, and pix_cnt SHALL clear to 0.
REQ-031 A pixel with both in_sof and in_eol SHALL yield line_len=1.
REQ-032 Pixels accepted before the first sof SHALL be converted with the reset-value active mode/threshold.

Reset
REQ-033 During reset: in_ready=0, out_valid=0, out_rgb=0, out_sof=0, out_eol=0, line_len=0, line_len_vld=0, occupancy=0, pix_cnt=0, active mode=0, active thresh=128.
REQ-034 Reset mid-operation SHALL discard all in-flight and buffered pixels; in_ready SHALL be 1 on the first cycle after deassertion.

Structure
REQ-035 Package gray2rgb_pkg SHALL hold the mode encodings, the RGB565 field positions, and the default threshold (128).
REQ-036 The output buffer SHALL be a sub-module px_fifo, 18 bits wide ({sof,eol,rgb}), FIFO_DEPTH entries, synchronous, with the head entry presented registered.

Verification
REQ-037 Mode 0, sof pixel g=8'hFF, out_ready=1 -> 16'hFFFF out_sof=1 two cycles after acceptance; g=8'h80 -> 16'h8410.
REQ-038 Mode 1, pixels g=0,63,128,255 -> 16'h001F, 16'h07FF, 16'h07E0, 16'hF800.
REQ-039 Mode 2 thresh=100, g=99,100 -> 16'h0000, 16'hFFFF; change mode mid-frame -> no effect until next sof.
REQ-040 out_ready=0, stream 6 pixels -> exactly 4 accepted, in_ready=0, data held; release -> all 4 delivered in order, none lost or duplicated.
REQ-041 Line of 640 pixels with eol on last -> line_len=640 with one-cycle line_len_vld; sof+eol single pixel -> line_len=1.
REQ-042 Assert rst_n low with 3 pixels buffered -> out_valid=0 immediately; after release, in_ready=1 and no stale pixel emerges.
